// File: rtl/encoder4_2_with_handshake_pkg.sv
// Shared constants for the 4-to-2 handshake encoder: sizes, FSM state codes and a
// one-hot helper used to retire the acknowledged request.
package encoder_pkg;

    localparam int IDX_W = 2;
    localparam int N_REQ = 4;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/encoder4_2_with_handshake_prio_select4.sv
// Combinational winner selection over the registered pending bits: highest index in
// fixed mode, or the first set index after 'last' (wrapping) in round-robin mode.
module prio_select4
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] last,
    input  logic             rr,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    logic [IDX_W-1:0] probe;

    // Both scans run from the least to the most preferred candidate so the final
    // overwrite leaves the winner; in round-robin, k=N_REQ wraps onto 'last' itself.
    always_comb begin
        idx   = '0;
        hit   = 1'b0;
        probe = '0;
        if (rr) begin
            for (int k = N_REQ; k >= 1; k--) begin
                probe = last + IDX_W'(k);
                if (pending[probe]) begin
                    idx = probe;
                    hit = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pending[i]) begin
                    idx = IDX_W'(i);
                    hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/encoder4_2_with_handshake.sv
// Sequential 4-to-2 priority encoder: sticky request capture, registered {A,B} code
// with a valid/ack handshake, and a one-cycle pulse for requests that were already pending.
module encoder4_2_with_handshake
    import encoder_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic ack,
    output logic A,
    output logic B,
    output logic valid,
    output logic dropped,
    output logic pending_any
);

    localparam logic RR_MODE = (ROUND_ROBIN != 0);

    logic [0:0]       state;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] clear_mask;
    logic [N_REQ-1:0] pending_next;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_hit;
    logic             take;

    assign req          = enable ? {D3, D2, D1, D0} : '0;
    assign take         = (state == PRESENT) && ack;
    assign clear_mask   = take ? onehot({A, B}) : '0;
    // A fresh request on the bit being retired survives because the OR comes last.
    assign pending_next = (pending & ~clear_mask) | req;
    assign pending_any  = |pending;

    prio_select4 u_select (
        .pending (pending),
        .last    (last),
        .rr      (RR_MODE),
        .idx     (sel_idx),
        .hit     (sel_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            last    <= 2'd3;
            A       <= 1'b0;
            B       <= 1'b0;
            valid   <= 1'b0;
            dropped <= 1'b0;
        end else begin
            pending <= pending_next;
            dropped <= |(req & pending & ~clear_mask);
            case (state)
                IDLE: begin
                    if (sel_hit) begin
                        {A, B} <= sel_idx;
                        valid  <= 1'b1;
                        state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        last  <= {A, B};
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder4_2_with_handshake.sv
// Bench for encoder4_2_with_handshake: fixed-priority and round-robin instances share
// stimulus; directed scenarios use constant expectations, the random run uses a reference model.
module tb_encoder4_2_with_handshake;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ack;
    logic [3:0] d;
    logic [1:0] a_o, b_o, valid_o, dropped_o, pany_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model, index 0 = fixed priority, index 1 = round-robin.
    bit m_pend  [2][4];
    bit m_valid [2];
    int m_code  [2];
    int m_last  [2];
    bit m_drop  [2];

    always #5 clk = ~clk;

    encoder4_2_with_handshake #(.ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst), .enable(enable),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .ack(ack),
        .A(a_o[0]), .B(b_o[0]), .valid(valid_o[0]),
        .dropped(dropped_o[0]), .pending_any(pany_o[0])
    );

    encoder4_2_with_handshake #(.ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst(rst), .enable(enable),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .ack(ack),
        .A(a_o[1]), .B(b_o[1]), .valid(valid_o[1]),
        .dropped(dropped_o[1]), .pending_any(pany_o[1])
    );

    function automatic int pick(int k);
        if (k == 0) begin
            for (int i = 3; i >= 0; i--)
                if (m_pend[k][i]) return i;
        end else begin
            for (int s = 1; s <= 4; s++)
                if (m_pend[k][(m_last[k] + s) % 4]) return (m_last[k] + s) % 4;
        end
        return -1;
    endfunction

    function automatic logic [4:0] model_out(int k);
        logic [1:0] c;
        logic       any;
        c   = 2'(m_code[k]);
        any = 1'b0;
        for (int i = 0; i < 4; i++) any = any | m_pend[k][i];
        return {c, m_valid[k], m_drop[k], any};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) m_pend[k][i] = 1'b0;
            m_valid[k] = 1'b0;
            m_code[k]  = 0;
            m_last[k]  = 3;
            m_drop[k]  = 1'b0;
        end
    endtask

    // Advance one clock: the model consumes the inputs present at the edge.
    task automatic tick();
        bit np [2][4];
        bit nv [2];
        int nc [2];
        int nl [2];
        bit nd [2];
        int clr, sel;
        bit r;
        for (int k = 0; k < 2; k++) begin
            clr   = (m_valid[k] && ack) ? m_code[k] : -1;
            nd[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                r = enable && d[i];
                if (r && m_pend[k][i] && i != clr) nd[k] = 1'b1;
                np[k][i] = (m_pend[k][i] && i != clr) || r;
            end
            nv[k] = m_valid[k];
            nc[k] = m_code[k];
            nl[k] = m_last[k];
            if (m_valid[k]) begin
                if (ack) begin
                    nv[k] = 1'b0;
                    nl[k] = m_code[k];
                end
            end else begin
                sel = pick(k);
                if (sel >= 0) begin
                    nv[k] = 1'b1;
                    nc[k] = sel;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) m_pend[k][i] = np[k][i];
            m_valid[k] = nv[k];
            m_code[k]  = nc[k];
            m_last[k]  = nl[k];
            m_drop[k]  = nd[k];
        end
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        d      = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            obs = {a_o[k], b_o[k], valid_o[k], dropped_o[k], pany_o[k]};
            n_checks++;
            if (obs !== 5'b00000) begin
                n_fail++;
                $display("[TB] FAIL reset_state dut%0d: got %b expected %b", k, obs, 5'b00000);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            obs = {a_o[k], b_o[k], valid_o[k], dropped_o[k], pany_o[k]};
            n_checks++;
            if (obs !== 5'b00000) begin
                n_fail++;
                $display("[TB] FAIL reset_idle dut%0d: got %b expected %b", k, obs, 5'b00000);
            end
        end
    endtask

    task automatic test_single_request();
        logic [2:0] obs;
        apply_reset();
        enable = 1'b1;
        d      = 4'b0100;
        tick();
        d = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({valid_o[k], pany_o[k]} !== 2'b01) begin
                n_fail++;
                $display("[TB] FAIL single_latency dut%0d: got %b expected %b", k, {valid_o[k], pany_o[k]}, 2'b01);
            end
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                obs = {a_o[k], b_o[k], valid_o[k]};
                n_checks++;
                if (obs !== 3'b101) begin
                    n_fail++;
                    $display("[TB] FAIL single_hold%0d dut%0d: got %b expected %b", c, k, obs, 3'b101);
                end
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({valid_o[k], pany_o[k]} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL single_ack dut%0d: got %b expected %b", k, {valid_o[k], pany_o[k]}, 2'b00);
            end
        end
    endtask

    // Serves every grant in turn; exp_fp / exp_rr give the order each instance must follow.
    task automatic serve_sequence(input string name, input int count,
                                  input logic [1:0] exp_fp [4], input logic [1:0] exp_rr [4]);
        logic [2:0] obs, want;
        for (int g = 0; g < count; g++) begin
            for (int k = 0; k < 2; k++) begin
                obs  = {a_o[k], b_o[k], valid_o[k]};
                want = {(k == 0) ? exp_fp[g] : exp_rr[g], 1'b1};
                n_checks++;
                if (obs !== want) begin
                    n_fail++;
                    $display("[TB] FAIL %s_grant%0d dut%0d: got %b expected %b", name, g, k, obs, want);
                end
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (valid_o[k] !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL %s_bubble%0d dut%0d: got %b expected 0", name, g, k, valid_o[k]);
                end
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({valid_o[k], pany_o[k]} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL %s_drained dut%0d: got %b expected %b", name, k, {valid_o[k], pany_o[k]}, 2'b00);
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp_fp [4];
        logic [1:0] exp_rr [4];
        exp_fp = '{2'd3, 2'd1, 2'd0, 2'd0};
        exp_rr = '{2'd0, 2'd1, 2'd3, 2'd0};
        apply_reset();
        enable = 1'b1;
        d      = 4'b1011;
        tick();
        d = 4'b0000;
        tick();
        serve_sequence("fixed", 3, exp_fp, exp_rr);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_fp [4];
        logic [1:0] exp_rr [4];
        exp_fp = '{2'd3, 2'd2, 2'd1, 2'd0};
        exp_rr = '{2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        enable = 1'b1;
        d      = 4'b0010;
        tick();
        d = 4'b0000;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        d   = 4'b1111;
        tick();
        d = 4'b0000;
        tick();
        serve_sequence("rr", 4, exp_fp, exp_rr);
    endtask

    task automatic test_drop();
        logic [3:0] obs;
        apply_reset();
        enable = 1'b1;
        d      = 4'b0010;
        tick();
        d = 4'b0000;
        tick();
        d = 4'b0010;
        tick();
        d = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            obs = {a_o[k], b_o[k], valid_o[k], dropped_o[k]};
            n_checks++;
            if (obs !== 4'b0111) begin
                n_fail++;
                $display("[TB] FAIL drop_pulse dut%0d: got %b expected %b", k, obs, 4'b0111);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            obs = {a_o[k], b_o[k], valid_o[k], dropped_o[k]};
            n_checks++;
            if (obs !== 4'b0110) begin
                n_fail++;
                $display("[TB] FAIL drop_one_cycle dut%0d: got %b expected %b", k, obs, 4'b0110);
            end
        end
        ack = 1'b1;
        d   = 4'b0010;
        tick();
        ack = 1'b0;
        d   = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            obs = {1'b0, valid_o[k], dropped_o[k], pany_o[k]};
            n_checks++;
            if (obs !== 4'b0001) begin
                n_fail++;
                $display("[TB] FAIL drop_set_wins dut%0d: got %b expected %b", k, obs, 4'b0001);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            obs = {a_o[k], b_o[k], valid_o[k], dropped_o[k]};
            n_checks++;
            if (obs !== 4'b0110) begin
                n_fail++;
                $display("[TB] FAIL drop_represent dut%0d: got %b expected %b", k, obs, 4'b0110);
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_enable_gate();
        logic [2:0] obs;
        apply_reset();
        enable = 1'b0;
        d      = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({valid_o[k], pany_o[k]} !== 2'b00) begin
                    n_fail++;
                    $display("[TB] FAIL gate_ignored%0d dut%0d: got %b expected %b", c, k, {valid_o[k], pany_o[k]}, 2'b00);
                end
            end
        end
        enable = 1'b1;
        d      = 4'b0001;
        tick();
        enable = 1'b0;
        d      = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                obs = {a_o[k], b_o[k], valid_o[k]};
                n_checks++;
                if (obs !== 3'b001) begin
                    n_fail++;
                    $display("[TB] FAIL gate_present%0d dut%0d: got %b expected %b", c, k, obs, 3'b001);
                end
            end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({valid_o[k], pany_o[k]} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL gate_drained dut%0d: got %b expected %b", k, {valid_o[k], pany_o[k]}, 2'b00);
            end
        end
        d = 4'b0000;
    endtask

    task automatic test_async_reset();
        logic [4:0] obs;
        apply_reset();
        enable = 1'b1;
        d      = 4'b0010;
        tick();
        d = 4'b0000;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({a_o[k], b_o[k], valid_o[k]} !== 3'b011) begin
                n_fail++;
                $display("[TB] FAIL areset_pre dut%0d: got %b expected %b", k, {a_o[k], b_o[k], valid_o[k]}, 3'b011);
            end
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            obs = {a_o[k], b_o[k], valid_o[k], dropped_o[k], pany_o[k]};
            n_checks++;
            if (obs !== 5'b00000) begin
                n_fail++;
                $display("[TB] FAIL areset_immediate dut%0d: got %b expected %b", k, obs, 5'b00000);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({valid_o[k], pany_o[k]} !== 2'b00) begin
                    n_fail++;
                    $display("[TB] FAIL areset_idle%0d dut%0d: got %b expected %b", c, k, {valid_o[k], pany_o[k]}, 2'b00);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] obs;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            d      = 4'($urandom) & 4'($urandom);
            ack    = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k < 2; k++) begin
                obs = {a_o[k], b_o[k], valid_o[k], dropped_o[k], pany_o[k]};
                n_checks++;
                if (obs !== model_out(k)) begin
                    n_fail++;
                    $display("[TB] FAIL random_c%0d dut%0d: got %b expected %b", c, k, obs, model_out(k));
                end
            end
        end
        d      = 4'b0000;
        enable = 1'b0;
        ack    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        d      = 4'b0000;
        model_reset();
        test_reset();
        test_single_request();
        test_fixed_priority();
        test_round_robin();
        test_drop();
        test_enable_gate();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
